// File: rtl/obi_apb_bridge_pkg.sv
// Shared types and helpers for the OBI-to-APB byte-lane bridge.
package obi_apb_bridge_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  // Isolate the lowest set bit of a lane mask (one-hot result, zero for zero input).
  function automatic logic [LANES-1:0] lowest_lane(input logic [LANES-1:0] mask);
    return mask & (~mask + {{(LANES-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/obi_apb_byte_bridge.sv
// Single-outstanding OBI-to-APB bridge for byte-wide peripherals. Each enabled
// byte lane becomes its own APB transfer with a one-hot pstrb; read lanes are
// merged into one OBI response. Optional pready timeout.
module obi_apb_byte_bridge
  import obi_apb_bridge_pkg::*;
#(
  parameter bit          BYTE_SPLIT     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // OBI side
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [31:0]       obi_addr_i,
  input  logic              obi_we_i,
  input  logic [LANES-1:0]  obi_be_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  // APB side
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [31:0]       paddr_o,
  output logic [31:0]       pwdata_o,
  output logic [LANES-1:0]  pstrb_o,
  input  logic [31:0]       prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  state_e            state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_acc_q;
  logic              we_q;
  logic              err_q;
  logic [LANES-1:0]  pend_q;
  logic [LANES-1:0]  lane_cur;
  logic [LANES-1:0]  pend_next;
  logic              accept;
  logic              beat_done;
  logic              timeout_hit;

  // Lane served by the current SETUP/ACCESS pair; pend_q is stable across both phases.
  assign lane_cur  = BYTE_SPLIT ? lowest_lane(pend_q) : pend_q;
  assign pend_next = pend_q & ~lane_cur;
  assign accept    = (state_q == IDLE) && obi_req_i;
  assign beat_done = (state_q == ACCESS) && pready_i;

  // Optional pready watchdog: counts ACCESS wait cycles, restarts on every SETUP.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    logic [CNT_W-1:0] cnt_q;

    // Wait-cycle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign timeout_hit = (state_q == ACCESS) && !pready_i &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // Next-state logic for the bridge FSM.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (obi_req_i) state_d = (obi_be_i == '0) ? RESP : SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = (pslverr_i || (pend_next == '0)) ? RESP : SETUP;
        end else if (timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request capture, lane bookkeeping, read-data merge and error accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: datapath registers are reset as well, so APB/OBI outputs read 0 straight out of reset.
    if (!rst_ni) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      pend_q      <= '0;
      rdata_acc_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= obi_addr_i & ~32'h3;
        wdata_q <= obi_wdata_i;
        we_q    <= obi_we_i;
        pend_q  <= obi_be_i;
      end else if (beat_done) begin
        pend_q <= pend_next;
      end

      if (beat_done && !we_q) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_cur[i]) rdata_acc_q[8*i +: 8] <= prdata_i[8*i +: 8];
        end
      end

      if ((beat_done && pslverr_i) || timeout_hit) err_q <= 1'b1;

      if (state_q == RESP) begin
        rdata_acc_q <= '0;
        err_q       <= 1'b0;
      end
    end
  end

  // OBI outputs.
  assign obi_gnt_o    = accept;
  assign obi_rvalid_o = (state_q == RESP);
  assign obi_rdata_o  = obi_rvalid_o ? rdata_acc_q : '0;
  assign obi_err_o    = obi_rvalid_o & err_q;

  // APB outputs; address/data/strobe are only presented while selected.
  assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = psel_o & we_q;
  assign paddr_o   = psel_o ? addr_q  : '0;
  assign pwdata_o  = psel_o ? wdata_q : '0;
  assign pstrb_o   = psel_o ? lane_cur : '0;

endmodule

// File: tb/tb_obi_apb_byte_bridge.sv
// Directed bench for obi_apb_byte_bridge: a vector table run through a small
// APB responder, plus reset-state and reset-during-ACCESS sequences.
module tb_obi_apb_byte_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  obi_apb_byte_bridge #(
    .BYTE_SPLIT     (1'b1),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] prdata;     // slave read data on every beat
    int          waits;      // pready-low cycles before each beat
    int          err_beat;   // beat index answered with pslverr, -1 = none
    int          exp_beats;  // completed APB transfers
    logic [15:0] exp_strb;   // pstrb of beat k in bits [4k+3:4k]
    logic [31:0] exp_paddr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // cycles from gnt to rvalid
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] prdata,
                              input int waits, input int err_beat, input int exp_beats,
                              input logic [15:0] exp_strb, input logic [31:0] exp_paddr,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.prdata = prdata;
    v.waits = waits; v.err_beat = err_beat; v.exp_beats = exp_beats;
    v.exp_strb = exp_strb; v.exp_paddr = exp_paddr; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Issue one OBI request (called at a negedge) and act as the APB slave until rvalid.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat = -1;
    int          beats = 0;
    int          waited = 0;
    int          bad_gnt = 0;
    int          bad_rdata = 0;
    logic [15:0] strb_seen = '0;
    logic [31:0] paddr_seen = '0;
    logic [31:0] pwdata_seen = '0;
    logic        pwrite_seen = 1'b0;
    logic [31:0] rd = '0;
    logic        er = 1'b0;

    obi_req_i   = 1'b1;
    obi_we_i    = v.we;
    obi_addr_i  = v.addr;
    obi_be_i    = v.be;
    obi_wdata_i = v.wdata;
    #1;
    check($sformatf("v%0d gnt", idx), 32'(obi_gnt_o), 32'd1);

    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      if (obi_rvalid_o) begin
        lat       = cyc;
        rd        = obi_rdata_o;
        er        = obi_err_o;
        obi_req_i = 1'b0;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        break;
      end
      // Request is held high while busy: it must not be granted again.
      if (obi_gnt_o) bad_gnt++;
      if (obi_rdata_o != '0) bad_rdata++;
      if (psel_o && penable_o) begin
        if (waited < v.waits) begin
          pready_i  = 1'b0;
          pslverr_i = 1'b0;
          waited++;
        end else begin
          pready_i  = 1'b1;
          pslverr_i = (beats == v.err_beat);
          prdata_i  = v.prdata;
          if (beats < 4) strb_seen[4*beats +: 4] = pstrb_o;
          paddr_seen  = paddr_o;
          pwdata_seen = pwdata_o;
          pwrite_seen = pwrite_o;
          beats++;
          waited = 0;
        end
      end else begin
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
      end
    end
    obi_req_i = 1'b0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;

    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d beats", idx), 32'(beats), 32'(v.exp_beats));
    check($sformatf("v%0d pstrb seq", idx), 32'(strb_seen), 32'(v.exp_strb));
    check($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d err", idx), 32'(er), 32'(v.exp_err));
    check($sformatf("v%0d gnt while busy", idx), 32'(bad_gnt), 32'd0);
    check($sformatf("v%0d rdata idle", idx), 32'(bad_rdata), 32'd0);
    if (beats > 0) begin
      check($sformatf("v%0d paddr", idx), paddr_seen, v.exp_paddr);
      check($sformatf("v%0d pwrite", idx), 32'(pwrite_seen), 32'(v.we));
      if (v.we) check($sformatf("v%0d pwdata", idx), pwdata_seen, v.wdata);
    end

    @(negedge clk_i);
    check($sformatf("v%0d rvalid pulse", idx), 32'(obi_rvalid_o), 32'd0);
  endtask

  initial begin
    int rv_seen;

    //         we    addr          be       wdata         prdata        wt  eb  nb strb      paddr         rdata         err  lat
    vecs[0]  = mk(1'b1, 32'h4000_0010, 4'b0001, 32'h0000_0041, 32'h0,        0, -1, 1, 16'h0001, 32'h4000_0010, 32'h0,        1'b0, 3);
    vecs[1]  = mk(1'b1, 32'h4000_0013, 4'b1010, 32'hAABB_CCDD, 32'h0,        0, -1, 2, 16'h0082, 32'h4000_0010, 32'h0,        1'b0, 5);
    vecs[2]  = mk(1'b0, 32'h4000_0020, 4'b1111, 32'h0,         32'h1122_3344, 0, -1, 4, 16'h8421, 32'h4000_0020, 32'h1122_3344, 1'b0, 9);
    vecs[3]  = mk(1'b0, 32'h4000_0104, 4'b0110, 32'h0,         32'h0000_3300, 0,  0, 1, 16'h0002, 32'h4000_0104, 32'h0000_3300, 1'b1, 3);
    vecs[4]  = mk(1'b0, 32'h4000_0008, 4'b0000, 32'h0,         32'hFFFF_FFFF, 0, -1, 0, 16'h0000, 32'h0,         32'h0,        1'b0, 1);
    vecs[5]  = mk(1'b0, 32'h4000_000C, 4'b0100, 32'h0,         32'hA5B6_C7D8, 0, -1, 1, 16'h0004, 32'h4000_000C, 32'h00B6_0000, 1'b0, 3);
    vecs[6]  = mk(1'b0, 32'h4000_0031, 4'b1001, 32'h0,         32'hDEAD_BEEF, 0, -1, 2, 16'h0081, 32'h4000_0030, 32'hDE00_00EF, 1'b0, 5);
    vecs[7]  = mk(1'b1, 32'h4000_0040, 4'b1111, 32'h0102_0304, 32'h0,        0, -1, 4, 16'h8421, 32'h4000_0040, 32'h0,        1'b0, 9);
    vecs[8]  = mk(1'b0, 32'h4000_0050, 4'b0011, 32'h0,         32'h0000_CAFE, 2, -1, 2, 16'h0021, 32'h4000_0050, 32'h0000_CAFE, 1'b0, 9);
    vecs[9]  = mk(1'b0, 32'h4000_0060, 4'b1110, 32'h0,         32'h5566_7788, 0,  1, 2, 16'h0042, 32'h4000_0060, 32'h0066_7700, 1'b1, 5);
    vecs[10] = mk(1'b0, 32'h4000_0070, 4'b0001, 32'h0,         32'h0000_0099, 15, -1, 0, 16'h0000, 32'h0,        32'h0,        1'b1, 6);
    vecs[11] = mk(1'b1, 32'h4000_0010, 4'b0001, 32'h0000_0041, 32'h0,        0, -1, 1, 16'h0001, 32'h4000_0010, 32'h0,        1'b0, 3);

    rst_ni      = 1'b0;
    obi_req_i   = 1'b0;
    obi_addr_i  = '0;
    obi_we_i    = 1'b0;
    obi_be_i    = '0;
    obi_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;

    repeat (2) @(negedge clk_i);
    check("reset apb ctrl", {29'd0, psel_o, penable_o, pwrite_o}, 32'd0);
    check("reset obi ctrl", {29'd0, obi_gnt_o, obi_rvalid_o, obi_err_o}, 32'd0);
    check("reset paddr", paddr_o, 32'd0);
    check("reset pwdata", pwdata_o, 32'd0);
    check("reset pstrb", 32'(pstrb_o), 32'd0);
    check("reset rdata", obi_rdata_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Table: single/multi-lane, wait states, slave errors, be==0, timeout and recovery.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted while ACCESS is waiting on pready.
    obi_req_i   = 1'b1;
    obi_we_i    = 1'b0;
    obi_addr_i  = 32'h4000_0080;
    obi_be_i    = 4'b1111;
    @(negedge clk_i);            // SETUP
    obi_req_i = 1'b0;
    @(negedge clk_i);            // ACCESS, pready low
    check("pre-reset in ACCESS", {30'd0, psel_o, penable_o}, 32'd3);
    rst_ni = 1'b0;
    #1;
    check("reset mid-access psel/penable", {30'd0, psel_o, penable_o}, 32'd0);
    rv_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      if (obi_rvalid_o) rv_seen++;
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      if (obi_rvalid_o || psel_o) rv_seen++;
    end
    check("no response after reset", 32'(rv_seen), 32'd0);
    run_vec(20, vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
